// File: rtl/pdm_ctrl_pkg.sv
// Shared types and defaults for the PDM microphone capture controller.
// The capture index picks which mic_clk phase edge samples the data line.
package pdm_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAKE = 2'd1,
      RUN  = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam int CLK_DIV_DEF      = 8;
   localparam int WAKE_SAMPLES_DEF = 256;
   localparam int PCM_WIDTH_DEF    = 16;

   // Channel 0 samples at the end of the low phase, channel 1 at the end of the high phase.
   function automatic int cap_index(input int clk_div, input int channel);
      return (channel == 0) ? clk_div - 1 : clk_div / 2 - 1;
   endfunction

endpackage

// File: rtl/pcm_fifo.sv
// First-word-fall-through PCM sample FIFO with occupancy count and sticky overrun.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module pcm_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_req,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   input  logic                   clr_ovr,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overrun
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_inc;
   logic             full;
   logic             do_rd;
   logic             do_wr;
   logic             drop;

   assign full       = (count == (AW + 1)'(DEPTH));
   assign rd_empty   = (count == '0);
   assign do_rd      = rd_en & ~rd_empty;
   assign do_wr      = wr_req & (~full | do_rd);
   assign drop       = wr_req & full & ~do_rd;
   assign rd_ptr_inc = rd_ptr + 1'b1;

   // NOTE: the storage array is deliberately left out of reset; only pointers and count
   // define which entries are meaningful, so clearing it would buy nothing.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
         rd_data <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr_inc;

         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (drop)         overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;

         // Head register tracks the oldest entry; a write into an empty slot bypasses memory.
         if (do_rd) begin
            if (count > (AW + 1)'(1)) rd_data <= mem[rd_ptr_inc];
            else if (do_wr)           rd_data <= wr_data;
         end else if (do_wr && rd_empty) begin
            rd_data <= wr_data;
         end
      end
   end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM microphone front-end sequencer: mic clock divider, data capture, decimator
// reset control, wake-up sample discard and PCM buffering.
module pdm_capture_ctrl
   import pdm_ctrl_pkg::*;
#(
   parameter int CLK_DIV      = CLK_DIV_DEF,
   parameter int CHANNEL      = 0,
   parameter int WAKE_SAMPLES = WAKE_SAMPLES_DEF,
   parameter int FIFO_DEPTH   = 8,
   parameter int PCM_WIDTH    = PCM_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        enable,
   input  logic                        clr_ovr,
   output logic                        mic_clk,
   input  logic                        mic_data,
   output logic                        pdm_bit,
   output logic                        pdm_valid,
   output logic                        cic_rst_n,
   input  logic [PCM_WIDTH-1:0]        cic_dout,
   input  logic                        cic_dout_valid,
   input  logic                        rd_en,
   output logic [PCM_WIDTH-1:0]        rd_data,
   output logic                        rd_empty,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overrun,
   output logic [1:0]                  state
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int WW = $clog2(WAKE_SAMPLES + 1);

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
   localparam logic [DW-1:0] CAP_IDX   = DW'(cap_index(CLK_DIV, CHANNEL));
   localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_SAMPLES - 1);

   state_t        state_q;
   state_t        state_d;
   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_d;
   logic [DW-1:0] div_inc;
   logic [WW-1:0] wake_cnt;
   logic [WW-1:0] wake_d;
   logic          sync1;
   logic          sync2;
   logic          start;
   logic          running;
   logic          capture;
   logic          accept;

   assign state   = state_q;
   assign div_inc = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
   assign running = (state_q != IDLE);
   assign capture = running && (div_cnt == CAP_IDX);
   assign accept  = (state_q == RUN) && cic_dout_valid;

   // NOTE: every combinational output gets a default before the case so no path
   // leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      div_d   = div_cnt;
      wake_d  = wake_cnt;
      start   = 1'b0;
      unique case (state_q)
         IDLE: begin
            div_d = '0;
            if (enable) begin
               state_d = WAKE;
               wake_d  = '0;
               start   = 1'b1;
            end
         end
         WAKE: begin
            div_d = div_inc;
            if (!enable) begin
               state_d = STOP;
            end else if (cic_dout_valid) begin
               wake_d = wake_cnt + 1'b1;
               if (wake_cnt == WAKE_LAST) state_d = RUN;
            end
         end
         RUN: begin
            div_d = div_inc;
            if (!enable) state_d = STOP;
         end
         STOP: begin
            // Finish the current mic_clk period so the line ends low without a runt pulse.
            div_d = div_inc;
            if (div_cnt == DIV_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         div_cnt   <= '0;
         wake_cnt  <= '0;
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         mic_clk   <= 1'b0;
         cic_rst_n <= 1'b0;
         pdm_bit   <= 1'b0;
         pdm_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt   <= div_d;
         wake_cnt  <= wake_d;
         sync1     <= mic_data;
         sync2     <= sync1;
         mic_clk   <= (state_d != IDLE) && (div_d < DIV_HALF);
         cic_rst_n <= (state_d != IDLE);
         pdm_valid <= capture;
         if (capture) pdm_bit <= sync2;
      end
   end

   pcm_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PCM_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_req  (accept),
      .wr_data (cic_dout),
      .rd_en   (rd_en),
      .clr_ovr (clr_ovr | start),
      .rd_data (rd_data),
      .rd_empty(rd_empty),
      .count   (fifo_count),
      .overrun (overrun)
   );

endmodule
